// File: rtl/half_mat_v_sequencer.sv
// Row sequencer for half-precision matrix x vector: one dot-product per row via half_dot_v_v.
// Optional macro HALF_RELU_EN clamps negative results to zero before storage.
//
// state | meaning
// IDLE  | waiting for start; results hold
// ISSUE | dot_start pulse for the current row
// WAIT  | waiting for dot_done; capture dot_c into result[row]
// DONE  | one-cycle completion pulse
module half_mat_v_sequencer #(
  parameter int ROWS  = 10,
  parameter int WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] matrix [ROWS][WIDTH],
  input  logic [15:0] vector [WIDTH],
  output logic        dot_start,
  output logic [15:0] dot_vector_a [WIDTH],
  output logic [15:0] dot_vector_b [WIDTH],
  input  logic        dot_done,
  input  logic [15:0] dot_c,
  output logic        busy,
  output logic        done,
  output logic [15:0] result [ROWS]
);

  localparam int RW = $clog2(ROWS) + 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [15:0]   matrix_reg [ROWS][WIDTH];
  logic [15:0]   vector_reg [WIDTH];
  logic [15:0]   capture;

`ifdef HALF_RELU_EN
  assign capture = dot_c[15] ? 16'h0000 : dot_c;
`else
  assign capture = dot_c;
`endif

  // Row select as a compare-mux so ROWS=1 needs no zero-width index.
  always_comb begin
    for (int w = 0; w < WIDTH; w++) dot_vector_a[w] = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == RW'(r)) begin
        for (int w = 0; w < WIDTH; w++) dot_vector_a[w] = matrix_reg[r][w];
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WIDTH; w++) dot_vector_b[w] = vector_reg[w];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      dot_start <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        result[r] <= '0;
        for (int w = 0; w < WIDTH; w++) matrix_reg[r][w] <= '0;
      end
      for (int w = 0; w < WIDTH; w++) vector_reg[w] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < ROWS; r++) begin
              result[r] <= '0;
              for (int w = 0; w < WIDTH; w++) matrix_reg[r][w] <= matrix[r][w];
            end
            for (int w = 0; w < WIDTH; w++) vector_reg[w] <= vector[w];
            row       <= '0;
            dot_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          dot_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (dot_done) begin
            for (int r = 0; r < ROWS; r++) begin
              if (row == RW'(r)) result[r] <= capture;
            end
            if (row == LAST_ROW) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row       <= row + 1'b1;
              dot_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
